// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the async FIFO write port.
// The grant is held for a whole burst, which ends on req_last or after MAX_BURST beats.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_wfull,
    output logic                          fifo_winc,
    output logic [FIFO_WIDTH-1:0]         fifo_wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               busy_q, busy_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               beat;
    logic               last_g;
    logic [FIFO_WIDTH-1:0] data_g;

    // First valid requester at or after rr_ptr; descending scan so the nearest one wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int j;
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req_valid[IDX_W'(j)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(j);
            end
        end
    end

    // grant_q is one-hot (zero in IDLE), so an AND-OR mux selects the granted lane.
    always_comb begin
        data_g = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) data_g = data_g | req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

    assign last_g     = |(req_last & grant_q);
    assign beat       = (state_q == BURST) && (|(req_valid & grant_q)) && !fifo_wfull;
    assign fifo_winc  = beat;
    assign fifo_wdata = data_g;
    assign req_ready  = (state_q == BURST && !fifo_wfull) ? grant_q : '0;
    assign grant      = grant_q;
    assign busy       = busy_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d           = BURST;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    gidx_d            = pick_idx;
                    beat_cnt_d        = '0;
                    busy_d            = 1'b1;
                end
            end
            BURST: begin
                if (beat) begin
                    if (last_g || beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        busy_d     = 1'b0;
                        rr_ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural arbitration model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MB = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid, req_last, req_ready, grant;
    logic [N*W-1:0]   req_data;
    logic             fifo_wfull, fifo_winc, busy;
    logic [W-1:0]     fifo_wdata;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .fifo_wfull(fifo_wfull), .fifo_winc(fifo_winc),
        .fifo_wdata(fifo_wdata), .grant(grant), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit m_known  = 1'b0;
    bit m_busy   = 1'b0;
    int m_owner  = 0;
    int m_ptr    = 0;
    int m_beats  = 0;
    int winc_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [W-1:0] d);
        req_valid[i]        = v;
        req_last[i]         = l;
        req_data[i*W +: W]  = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
    endtask

    // One clock: compare outputs against the model, then advance the model at the edge.
    task automatic step();
        logic [N-1:0] e_grant;
        logic [N-1:0] e_ready;
        logic         e_winc;
        #1;
        e_grant = '0;
        if (m_busy) e_grant[m_owner] = 1'b1;
        e_winc  = m_busy && req_valid[m_owner] && !fifo_wfull;
        e_ready = (m_busy && !fifo_wfull) ? e_grant : '0;
        if (m_known) begin
            chk("grant", 64'(grant), 64'(e_grant));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("winc", 64'(fifo_winc), 64'(e_winc));
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            if (e_winc) chk("wdata", 64'(fifo_wdata), 64'(req_data[m_owner*W +: W]));
        end
        if (fifo_winc === 1'b1) winc_cnt++;
        @(posedge clk);
        if (!rst_n) begin
            m_known = 1'b1;
            m_busy  = 1'b0;
            m_ptr   = 0;
            m_beats = 0;
        end else if (m_known) begin
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    if (req_valid[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        m_busy  = 1'b1;
                        m_beats = 0;
                        break;
                    end
                end
            end else if (e_winc) begin
                m_beats++;
                if (req_last[m_owner] || m_beats == MB) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % N;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        fifo_wfull = 1'b0;
        clear_reqs();
        step();
        step();
        chk("reset_grant", 64'(grant), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_winc", 64'(fifo_winc), 64'h0);
        chk("reset_ready", 64'(req_ready), 64'h0);
        rst_n = 1'b1;

        // Single requester, three-beat packet.
        winc_cnt = 0;
        set_req(0, 1'b1, 1'b0, 16'hD000);
        step();
        chk("t1_grant", 64'(grant), 64'h1);
        step();
        set_req(0, 1'b1, 1'b0, 16'hD001);
        step();
        set_req(0, 1'b1, 1'b1, 16'hD002);
        step();
        clear_reqs();
        chk("t1_idle", 64'(grant), 64'h0);
        step();
        chk("t1_beats", 64'(winc_cnt), 64'd3);

        // Full contention with no req_last: MAX_BURST beats per grant.
        do_reset();
        winc_cnt  = 0;
        req_valid = '1;
        for (int c = 0; c < 20; c++) begin
            req_data = {$urandom, $urandom};
            step();
        end
        chk("t2_beats", 64'(winc_cnt), 64'd16);
        clear_reqs();
        step();

        // wfull stall for 5 cycles after beat 2.
        do_reset();
        set_req(0, 1'b1, 1'b0, 16'h3000);
        step();
        step();
        set_req(0, 1'b1, 1'b0, 16'h3001);
        step();
        fifo_wfull = 1'b1;
        set_req(0, 1'b1, 1'b0, 16'h3002);
        winc_cnt = 0;
        for (int c = 0; c < 5; c++) step();
        chk("t3_stall", 64'(winc_cnt), 64'd0);
        fifo_wfull = 1'b0;
        step();
        chk("t3_resume", 64'(winc_cnt), 64'd1);
        set_req(0, 1'b1, 1'b1, 16'h3003);
        step();
        clear_reqs();
        step();

        // Round-robin order after a grant to requester 2.
        do_reset();
        set_req(2, 1'b1, 1'b1, 16'h4222);
        step();
        step();
        clear_reqs();
        set_req(1, 1'b1, 1'b1, 16'h4111);
        set_req(3, 1'b1, 1'b1, 16'h4333);
        step();
        chk("t4_first", 64'(grant), 64'h8);
        step();
        set_req(3, 1'b0, 1'b0, 16'h0);
        step();
        chk("t4_second", 64'(grant), 64'h2);
        step();
        clear_reqs();
        step();

        // Reset in the middle of a burst.
        do_reset();
        set_req(1, 1'b1, 1'b0, 16'h5111);
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_grant", 64'(grant), 64'h0);
        chk("t5_busy", 64'(busy), 64'h0);
        chk("t5_winc", 64'(fifo_winc), 64'h0);
        set_req(0, 1'b1, 1'b1, 16'h5000);
        step();
        chk("t5_rr", 64'(grant), 64'h1);
        step();
        clear_reqs();
        step();

        // Granted valid drops for 3 cycles while another requester waits.
        do_reset();
        winc_cnt = 0;
        set_req(2, 1'b1, 1'b0, 16'h6002);
        step();
        step();
        step();
        set_req(2, 1'b0, 1'b0, 16'h0);
        set_req(0, 1'b1, 1'b0, 16'h6000);
        for (int c = 0; c < 3; c++) step();
        chk("t6_hold", 64'(grant), 64'h4);
        set_req(2, 1'b1, 1'b0, 16'h6012);
        step();
        step();
        step();
        chk("t6_cap", 64'(winc_cnt), 64'd4);
        chk("t6_next", 64'(grant), 64'h1);
        clear_reqs();
        for (int c = 0; c < 5; c++) step();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            rst_n      = ($urandom_range(79) != 0);
            fifo_wfull = ($urandom_range(4) == 0);
            for (int i = 0; i < N; i++) begin
                set_req(i, $urandom_range(3) != 0, $urandom_range(3) == 0, W'($urandom));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
